// File: rtl/spi_burst_ram_if.sv
// SPI pin bundle for spi_burst_ram: frame select and serial data in from the
// master, serial data out and status flags back from the slave.
interface spi_burst_ram_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic wr_strobe;
  logic par_err;

  modport master (output SS_n, MOSI, input MISO, busy, wr_strobe, par_err);
  modport slave  (input SS_n, MOSI, output MISO, busy, wr_strobe, par_err);
endinterface

// File: rtl/spi_burst_ram.sv
// SPI slave fronting an on-chip RAM with independent write/read pointers and burst transfers.
// Define SPI_BURST_RAM_PARITY_EN to add an even-parity bit after every word in both directions.
module spi_burst_ram #(
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  spi_burst_ram_if.slave bus
);

`ifdef SPI_BURST_RAM_PARITY_EN
  localparam int WORD_BITS = DATA_WIDTH + 1;
`else
  localparam int WORD_BITS = DATA_WIDTH;
`endif
  localparam int SW = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
  localparam int CW = $clog2(SW + 2);

  typedef enum logic [2:0] {IDLE, CMD, SET_WA, SET_RA, WRITE, RD_WAIT, READ} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           sh_q, sh_d;
  logic [ADDR_SIZE-1:0]    wptr_q, wptr_d;
  logic [ADDR_SIZE-1:0]    rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    rpar_q, rpar_d;
  logic                    miso_q, miso_d;
  logic                    busy_q, busy_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [ADDR_SIZE-1:0]    waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ss_prev_q, ss_prev_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   word_in;
  logic                    word_ok;

  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (32'(p) == 32'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_SIZE-1:0] ptr_wrap(input logic [ADDR_SIZE-1:0] a);
    return ADDR_SIZE'(32'(a) % 32'(MEM_DEPTH));
  endfunction

  assign rd_word = mem[rptr_q];

`ifdef SPI_BURST_RAM_PARITY_EN
  logic par_err_q, par_err_d;
  // Word bits are already in the shifter when the trailing parity bit arrives.
  assign word_in   = sh_q[DATA_WIDTH-1:0];
  assign word_ok   = ~(^sh_q[DATA_WIDTH-1:0] ^ bus.MOSI);
  assign par_err_d = par_err_q | (state_q == WRITE && !bus.SS_n &&
                                  cnt_q == CW'(WORD_BITS - 1) && !word_ok);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
  assign bus.par_err = par_err_q;
`else
  assign word_in     = sh_d[DATA_WIDTH-1:0];
  assign word_ok     = 1'b1;
  assign bus.par_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = {sh_q[SW-2:0], bus.MOSI};
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_d       = out_q;
    rpar_d      = rpar_q;
    miso_d      = 1'b0;
    wr_strobe_d = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    ss_prev_d   = bus.SS_n;

    if (bus.SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        // A frame starts only on a falling SS_n; address-load hold and
        // post-reset frames wait here until SS_n has been high.
        IDLE: if (ss_prev_q) state_d = CMD;
        CMD: begin
          cnt_d = '0;
          case ({sh_q[0], bus.MOSI})
            2'b00:   state_d = SET_WA;
            2'b01:   state_d = WRITE;
            2'b10:   state_d = SET_RA;
            default: state_d = RD_WAIT;
          endcase
        end
        SET_WA, SET_RA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ADDR_SIZE - 1)) begin
            if (state_q == SET_WA) wptr_d = ptr_wrap(sh_d[ADDR_SIZE-1:0]);
            else                   rptr_d = ptr_wrap(sh_d[ADDR_SIZE-1:0]);
            state_d = IDLE;
          end
        end
        WRITE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WORD_BITS - 1)) begin
            cnt_d = '0;
            if (word_ok) begin
              wr_strobe_d = 1'b1;
              waddr_d     = wptr_q;
              wdata_d     = word_in;
              wptr_d      = ptr_inc(wptr_q);
            end
          end
        end
        RD_WAIT: begin
          out_d   = rd_word;
          rpar_d  = ^rd_word;
          miso_d  = rd_word[DATA_WIDTH-1];
          rptr_d  = ptr_inc(rptr_q);
          cnt_d   = '0;
          state_d = READ;
        end
        READ: begin
          if (cnt_q == CW'(WORD_BITS - 1)) begin
            out_d  = rd_word;
            rpar_d = ^rd_word;
            miso_d = rd_word[DATA_WIDTH-1];
            rptr_d = ptr_inc(rptr_q);
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            out_d  = out_q << 1;
            miso_d = (cnt_q == CW'(DATA_WIDTH - 1)) ? rpar_q : out_q[DATA_WIDTH-2];
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_q       <= '0;
      rpar_q      <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ss_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_q       <= out_d;
      rpar_q      <= rpar_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ss_prev_q   <= ss_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_strobe_q) mem[waddr_q] <= wdata_q;
  end

  assign bus.MISO      = miso_q;
  assign bus.busy      = busy_q;
  assign bus.wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Randomized self-checking bench for spi_burst_ram against a word-level memory/pointer model.
module tb_spi_burst_ram;
  localparam int AW = 8, DEPTH = 256, DW = 8;
`ifdef SPI_BURST_RAM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_burst_ram_if bus();
  spi_burst_ram #(.ADDR_SIZE(AW), .MEM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] mem_m [DEPTH];
  int unsigned   wptr_m, rptr_m;
  logic [DW-1:0] wq [$];
  int            n_checks = 0, n_fail = 0;
  logic          obs_miso, obs_busy, obs_perr;
  int            cyc = 0, strobe_cnt = 0;
  int            strobe_cyc [$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.wr_strobe === 1'b1) begin
    strobe_cnt++;
    strobe_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs captured here reflect the previous rising edge.
  task automatic tick(input logic ss, input logic mosi);
    @(negedge clk);
    obs_miso = bus.MISO;
    obs_busy = bus.busy;
    obs_perr = bus.par_err;
    bus.SS_n = ss;
    bus.MOSI = mosi;
  endtask

  task automatic end_frame();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("idle_busy", 32'(obs_busy), 32'd0);
    check("idle_miso", 32'(obs_miso), 32'd0);
  endtask

  task automatic set_ptr(input bit is_read, input int unsigned a);
    tick(1'b0, is_read);
    tick(1'b0, 1'b0);
    check("addr_busy", 32'(obs_busy), 32'd1);
    for (int i = AW - 1; i >= 0; i--) begin
      tick(1'b0, a[i]);
      check("addr_busy", 32'(obs_busy), 32'd1);
      check("addr_miso", 32'(obs_miso), 32'd0);
    end
    end_frame();
    if (is_read) rptr_m = a % DEPTH;
    else         wptr_m = a % DEPTH;
  endtask

  task automatic write_burst(input int bad_idx);
    logic [DW-1:0] w;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    foreach (wq[k]) begin
      w = wq[k];
      for (int b = DW - 1; b >= 0; b--) tick(1'b0, w[b]);
      if (PAR != 0) tick(1'b0, (^w) ^ (k == bad_idx));
      if (PAR == 0 || k != bad_idx) begin
        mem_m[wptr_m] = w;
        wptr_m = (wptr_m + 1) % DEPTH;
      end
    end
    end_frame();
  endtask

  task automatic read_burst(input int nwords, input string tag);
    logic [DW-1:0] got;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    for (int k = 0; k < nwords; k++) begin
      got = '0;
      for (int b = 0; b < DW; b++) begin
        tick(1'b0, 1'b0);
        got = {got[DW-2:0], obs_miso};
      end
      check(tag, 32'(got), 32'(mem_m[rptr_m]));
      if (PAR != 0) begin
        tick(1'b0, 1'b0);
        check({tag, "_par"}, 32'(obs_miso), 32'(^mem_m[rptr_m]));
      end
      rptr_m = (rptr_m + 1) % DEPTH;
    end
    end_frame();
    // The word after the last one read was already prefetched.
    rptr_m = (rptr_m + 1) % DEPTH;
  endtask

  initial begin
    int s0, nw, bad;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    wptr_m = 0;
    rptr_m = 0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(bus.MISO), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_wstb", 32'(bus.wr_strobe), 32'd0);
    check("rst_perr", 32'(bus.par_err), 32'd0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    set_ptr(1'b0, 'h10);

    // Fill the whole RAM so every later read has a known expectation.
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(DW'($urandom));
    write_burst(-1);

    set_ptr(1'b0, 'h10);
    s0 = strobe_cnt;
    wq = '{8'hA5, 8'h3C, 8'hFF};
    write_burst(-1);
    check("burst_strobes", 32'(strobe_cnt - s0), 32'd3);
    check("strobe_gap1", 32'(strobe_cyc[s0+1] - strobe_cyc[s0]), 32'(DW + PAR));
    check("strobe_gap2", 32'(strobe_cyc[s0+2] - strobe_cyc[s0+1]), 32'(DW + PAR));
    wq = '{8'h77};
    write_burst(-1);
    set_ptr(1'b1, 'h10);
    read_burst(4, "burst_rd");

    set_ptr(1'b0, 'hFF);
    wq = '{8'h11, 8'h22};
    write_burst(-1);
    set_ptr(1'b1, 'hFF);
    read_burst(2, "wrap_rd");

    set_ptr(1'b0, 'h20);
    wq = '{8'h5A};
    write_burst(-1);
    set_ptr(1'b0, 'h20);
    s0 = strobe_cnt;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    for (int b = 0; b < 5; b++) tick(1'b0, 1'b1);
    end_frame();
    check("partial_nostrobe", 32'(strobe_cnt - s0), 32'd0);
    set_ptr(1'b1, 'h20);
    read_burst(1, "partial_rd");

    if (PAR != 0) begin
      set_ptr(1'b0, 'h30);
      s0 = strobe_cnt;
      wq = '{8'hA5, 8'h3C};
      write_burst(0);
      check("par_strobes", 32'(strobe_cnt - s0), 32'd1);
      check("par_err_set", 32'(bus.par_err), 32'd1);
      set_ptr(1'b1, 'h30);
      read_burst(1, "par_rd");
      check("par_err_sticky", 32'(bus.par_err), 32'd1);
    end

    // Reset in mid-frame: SS_n still low afterwards must not start a frame.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_perr", 32'(bus.par_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wptr_m = 0;
    rptr_m = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      check("postrst_nobusy", 32'(obs_busy), 32'd0);
    end
    end_frame();
    read_burst(2, "postrst_rd");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: set_ptr(1'b0, $urandom_range(0, (1 << AW) - 1));
        1: set_ptr(1'b1, $urandom_range(0, (1 << AW) - 1));
        2: begin
          nw = $urandom_range(1, 4);
          wq.delete();
          for (int i = 0; i < nw; i++) wq.push_back(DW'($urandom));
          bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nw - 1) : -1;
          write_burst(bad);
        end
        default: read_burst($urandom_range(1, 4), "rand_rd");
      endcase
    end
    check("final_perr", 32'(bus.par_err), 32'(obs_perr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
- Parametrised SPI slave with an on-chip single-port RAM. This is the next-generation SPI-to-memory endpoint.
- Adds configurable address and data widths, independent read and write pointers, and auto-incrementing burst transfers within one SS_n frame.
- MOSI and SS_n are sampled in the system clock domain. The block sits directly on the chip SPI pins.

Parameters:
- ADDR_SIZE, 8: address width in bits.
- MEM_DEPTH, 256: number of words; must satisfy MEM_DEPTH <= 2**ADDR_SIZE.
- DATA_WIDTH, 8: word width in bits, 4..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low; frame = contiguous low period.
- MOSI  input  1  serial data in, MSB first, sampled every clk while SS_n=0.
- MISO  output  1  serial data out, registered.
- busy  output  1  registered; 1 while a frame is in progress (state != IDLE).
- wr_strobe  output  1  one-cycle pulse on each RAM write.
- par_err  output  1  sticky parity-error flag (see Optional Feature).

Behaviour:
- Reset values: MISO=0, busy=0, wr_strobe=0, par_err=0, wptr=0, rptr=0, state=IDLE. RAM contents are not cleared.
- States: IDLE, CMD, SET_WA, SET_RA, WRITE, RD_WAIT, READ.
- IDLE -> CMD on the first clk with SS_n=0; that same edge samples command bit 1.
- CMD: 2 command bits, MSB first.
  - 00 -> SET_WA.
  - 01 -> WRITE.
  - 10 -> SET_RA.
  - 11 -> RD_WAIT.
- SET_WA / SET_RA: shift ADDR_SIZE bits; on the last bit load wptr/rptr and go to IDLE-hold. Further bits in the frame are ignored.
- Pointer value >= MEM_DEPTH on load is reduced modulo MEM_DEPTH.
- WRITE: shift DATA_WIDTH bits per word.
  - On the last bit of a word, mem[wptr] <= word next edge, wr_strobe=1 for that cycle.
  - wptr increments, wrapping MEM_DEPTH-1 -> 0.
  - Words repeat while SS_n stays low (burst).
- RD_WAIT: exactly 1 dummy clk. RAM read of mem[rptr] is registered; rptr increments with wrap.
- READ:
  - MISO presents word bits MSB first, one bit per clk. The first bit is valid the clk after RD_WAIT.
  - The next word is prefetched during the last bit, so consecutive words have no gap.
  - rptr increments at each prefetch.
- SS_n high at any time:
  - state -> IDLE on that edge; partial word or address is discarded (no write, no pointer load).
  - MISO=0 and busy=0 from the next edge.
  - Pointers keep their values; rptr has already advanced past prefetched words.
- Latency: write visible to a subsequent read 1 clk after wr_strobe.
- rst_n asserted mid-frame: immediate return to reset values. A frame in progress is abandoned; SS_n must go high before a new frame is recognised.
- Command and payload bits are sampled directly from MOSI. The SPI master must hold each bit for at least one clk; SPI sclk is not used.

Optional Feature:
- Macro: SPI_BURST_RAM_PARITY_EN.
- Enabled:
  - Each WRITE word is followed by 1 even-parity bit on MOSI.
  - If parity matches, the word is written. If it mismatches, the write is suppressed (no wr_strobe, wptr unchanged) and par_err is set.
  - par_err clears only on rst_n.
  - The burst continues with the next word.
  - Each READ word on MISO is followed by its even-parity bit before the next word.
- Disabled: no parity bits in either direction; par_err is tied to 0.

Test Plan:
- Reset, then SS_n=0 with frame 00+8'h10, then SS_n=1 -> wptr=8'h10, busy=1 during frame, MISO=0 throughout.
- Set wptr=8'h10; frame 01 + bytes A5,3C,FF -> three wr_strobe pulses 8 clks apart; mem[10..12]=A5,3C,FF; wptr=8'h13.
- Set rptr=8'h10; frame 11, 1 dummy clk -> MISO streams A5,3C,FF MSB first, 24 contiguous bits.
- Set wptr=8'hFF; write burst 11,22 -> mem[FF]=11, mem[00]=22 (wrap).
- SS_n high after 5 bits of a write word -> no wr_strobe, target word unchanged, next frame decoded normally.
- With SPI_BURST_RAM_PARITY_EN:
  - Write 8'hA5 with parity bit 1 (wrong) -> no write, par_err=1.
  - Then 8'h3C with parity 0 -> written; par_err stays 1.
